// File: rtl/step_profile_seq_pkg.sv
// step_pkg: shared types and constants for the step profile sequencer.
//
// Contents:
//   mode_t      activity mode encoding as seen on the mode input
//   state_t     sequencer state code (values S_IDLE .. S_DONE)
//   WALK_PER / JOG_PER / RUN_PER
//               half-periods (in clk cycles) for the fixed activity modes
//   fixed_per() maps a fixed mode to its half-period
package step_pkg;

  typedef enum logic [1:0] {
    WALK   = 2'b00,
    JOG    = 2'b01,
    RUN    = 2'b10,
    HYBRID = 2'b11
  } mode_t;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LOAD = 2'd1;
  localparam state_t S_RUN  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  localparam int unsigned WALK_PER = 1562500;
  localparam int unsigned JOG_PER  = 781250;
  localparam int unsigned RUN_PER  = 390625;

  // HYBRID has no fixed rate; it takes its periods from the table.
  function automatic int unsigned fixed_per(input mode_t m);
    case (m)
      WALK:    return WALK_PER;
      JOG:     return JOG_PER;
      RUN:     return RUN_PER;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/step_profile_seq_if.sv
// step_profile_seq_if: control, configuration and pulse-generator signals
// of the step profile sequencer, bundled for connection between a
// controller (master) and the sequencer (slave).
//
// Signals:
//   start, stop     single-cycle run requests
//   mode            activity mode, sampled on an accepted start
//   cfg_we/addr/per/dur
//                   profile table write port
//   pulse_en, half_per
//                   rate command to the pulse generator
//   seg_idx, sec_cnt
//                   profile position (segment, seconds within segment)
//   busy, done      run status, done is a one-cycle completion pulse
interface step_profile_seq_if #(
  parameter int unsigned SEG_N = 8,
  parameter int unsigned PER_W = 23,
  parameter int unsigned DUR_W = 9
);
  localparam int unsigned IDX_W = $clog2(SEG_N);

  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [PER_W-1:0] cfg_per;
  logic [DUR_W-1:0] cfg_dur;
  logic             pulse_en;
  logic [PER_W-1:0] half_per;
  logic [IDX_W-1:0] seg_idx;
  logic [DUR_W-1:0] sec_cnt;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, mode, cfg_we, cfg_addr, cfg_per, cfg_dur,
    input  pulse_en, half_per, seg_idx, sec_cnt, busy, done
  );

  modport slave (
    input  start, stop, mode, cfg_we, cfg_addr, cfg_per, cfg_dur,
    output pulse_en, half_per, seg_idx, sec_cnt, busy, done
  );

endinterface

// File: rtl/step_profile_seq_sec_tick_div.sv
// sec_tick_div: one-second tick generator.
//
// Counts enabled clk cycles 0..CLK_HZ-1 and raises tick combinationally
// during the cycle in which the count sits at CLK_HZ-1; the count wraps
// to 0 on that edge. clear restarts the second; the count holds while
// enable is low. Shared with the display and timer blocks.
//
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset
//   clear   restart the current second (count back to 0)
//   enable  advance the count
//   tick    one-cycle pulse at the end of each enabled second
module sec_tick_div #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_W'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/step_profile_seq.sv
// step_profile_seq: activity-profile sequencer driving the pedometer
// pulse generator.
//
// Fixed modes (walk/jog/run) hold a constant half-period until stopped,
// counting elapsed seconds (saturating). Hybrid mode walks a register-
// configured table of (half-period, duration-in-seconds) segments and
// switches rate on the one-second boundary that ends a segment. A
// duration of 0 marks the end of the profile.
//
// Build option:
//   SEQ_LOOP_EN  when defined, a hybrid profile that runs off its end
//                restarts at segment 0 (if that entry is non-empty),
//                pulsing done at each wrap and keeping pulse_en high.
//                When undefined the profile finishes through DONE.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    step_profile_seq_if slave: start/stop/mode control, table
//          write port, pulse generator command and status outputs
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; outputs quiet
//   LOAD   | one cycle: fetch first rate, clear second divider and sec_cnt
//   RUN    | pulse_en high; count seconds, advance hybrid segments
//   DONE   | one cycle: done pulse, rate cleared, back to IDLE
module step_profile_seq
  import step_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned SEG_N  = 8,
  parameter int unsigned PER_W  = 23,
  parameter int unsigned DUR_W  = 9
) (
  input logic               clk,
  input logic               reset,
  step_profile_seq_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(SEG_N);

  // Profile table, written any cycle; contents survive reset.
  logic [PER_W-1:0] tbl_per [SEG_N];
  logic [DUR_W-1:0] tbl_dur [SEG_N];

  state_t           state;
  mode_t            run_mode;
  logic [IDX_W-1:0] seg_idx;
  logic [DUR_W-1:0] sec_cnt;
  logic [DUR_W-1:0] cur_dur;
  logic [PER_W-1:0] half_per;
  logic             pulse_en;
  logic             done;

  logic             tick;
  logic [IDX_W-1:0] next_idx;
  logic             last_seg;
  logic             seg_end;
  logic             loop_ok;

  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      tbl_per[bus.cfg_addr] <= bus.cfg_per;
      tbl_dur[bus.cfg_addr] <= bus.cfg_dur;
    end
  end

  sec_tick_div #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == S_LOAD),
    .enable (state == S_RUN),
    .tick   (tick)
  );

  // next_idx wraps to 0 on the last entry; the index test catches that
  // case before the wrapped entry's duration matters.
  assign next_idx = seg_idx + IDX_W'(1);
  assign last_seg = (seg_idx == IDX_W'(SEG_N - 1)) || (tbl_dur[next_idx] == '0);
  assign seg_end  = tick && ((sec_cnt + DUR_W'(1)) == cur_dur);

`ifdef SEQ_LOOP_EN
  assign loop_ok = (tbl_dur[0] != '0);
`else
  assign loop_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      run_mode <= WALK;
      seg_idx  <= '0;
      sec_cnt  <= '0;
      cur_dur  <= '0;
      half_per <= '0;
      pulse_en <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            run_mode <= mode_t'(bus.mode);
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (bus.stop) begin
            state    <= S_IDLE;
            pulse_en <= 1'b0;
            half_per <= '0;
          end else begin
            seg_idx <= '0;
            sec_cnt <= '0;
            if (run_mode != HYBRID) begin
              half_per <= PER_W'(fixed_per(run_mode));
              pulse_en <= 1'b1;
              state    <= S_RUN;
            end else if (tbl_dur[0] == '0) begin
              done     <= 1'b1;
              pulse_en <= 1'b0;
              half_per <= '0;
              state    <= S_DONE;
            end else begin
              half_per <= tbl_per[0];
              cur_dur  <= tbl_dur[0];
              pulse_en <= 1'b1;
              state    <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (bus.stop) begin
            state    <= S_IDLE;
            pulse_en <= 1'b0;
            half_per <= '0;
          end else if (tick) begin
            if (run_mode != HYBRID) begin
              if (sec_cnt != '1) begin
                sec_cnt <= sec_cnt + DUR_W'(1);
              end
            end else if (!seg_end) begin
              sec_cnt <= sec_cnt + DUR_W'(1);
            end else if (!last_seg) begin
              // Rate and duration come from the table at the moment of the
              // advance; later writes to this entry wait for its next load.
              seg_idx  <= next_idx;
              sec_cnt  <= '0;
              half_per <= tbl_per[next_idx];
              cur_dur  <= tbl_dur[next_idx];
            end else if (loop_ok) begin
              seg_idx  <= '0;
              sec_cnt  <= '0;
              half_per <= tbl_per[0];
              cur_dur  <= tbl_dur[0];
              done     <= 1'b1;
            end else begin
              sec_cnt  <= '0;
              done     <= 1'b1;
              pulse_en <= 1'b0;
              half_per <= '0;
              state    <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pulse_en = pulse_en;
  assign bus.half_per = half_per;
  assign bus.seg_idx  = seg_idx;
  assign bus.sec_cnt  = sec_cnt;
  assign bus.busy     = (state == S_LOAD) || (state == S_RUN);
  assign bus.done     = done;

endmodule

// File: tb/tb_step_profile_seq.sv
module tb_step_profile_seq;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned SEG_N  = 8;
  localparam int unsigned PER_W  = 23;
  localparam int unsigned DUR_W  = 9;
  localparam int DUR_MAX = (1 << DUR_W) - 1;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  step_profile_seq_if #(.SEG_N(SEG_N), .PER_W(PER_W), .DUR_W(DUR_W)) bus ();

  step_profile_seq #(
    .CLK_HZ (CLK_HZ),
    .SEG_N  (SEG_N),
    .PER_W  (PER_W),
    .DUR_W  (DUR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: profile table mirror plus run position in plain ints.
  int tbl_per [SEG_N];
  int tbl_dur [SEG_N];
  int m_state = M_IDLE;
  int m_mode  = 0;
  int m_div   = 0;
  int m_seg   = 0;
  int m_sec   = 0;
  int m_dur   = 0;
  int m_half  = 0;
  bit m_pulse = 1'b0;
  bit m_done  = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rate_of(input int mode);
    case (mode)
      0:       return 1562500;
      1:       return 781250;
      2:       return 390625;
      default: return 0;
    endcase
  endfunction

  task automatic model_finish();
    m_state = M_DONE;
    m_done  = 1'b1;
    m_pulse = 1'b0;
    m_half  = 0;
    m_sec   = 0;
  endtask

  task automatic model_enter(input int idx);
    m_seg  = idx;
    m_sec  = 0;
    m_half = tbl_per[idx];
    m_dur  = tbl_dur[idx];
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (reset) begin
      m_state = M_IDLE; m_div = 0; m_seg = 0; m_sec = 0;
      m_dur = 0; m_half = 0; m_pulse = 1'b0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (bus.start && !bus.stop) begin
            m_mode  = int'(bus.mode);
            m_state = M_LOAD;
          end
        end
        M_LOAD: begin
          if (bus.stop) begin
            m_state = M_IDLE; m_pulse = 1'b0; m_half = 0;
          end else begin
            m_div = 0;
            m_seg = 0;
            m_sec = 0;
            if (m_mode != 3) begin
              m_half = rate_of(m_mode); m_pulse = 1'b1; m_state = M_RUN;
            end else if (tbl_dur[0] == 0) begin
              model_finish();
            end else begin
              model_enter(0); m_pulse = 1'b1; m_state = M_RUN;
            end
          end
        end
        M_RUN: begin
          if (bus.stop) begin
            m_state = M_IDLE; m_pulse = 1'b0; m_half = 0;
          end else begin
            m_div = m_div + 1;
            if (m_div == CLK_HZ) begin
              m_div = 0;
              if (m_mode != 3) begin
                if (m_sec < DUR_MAX) m_sec++;
              end else if (m_sec + 1 < m_dur) begin
                m_sec++;
              end else if (m_seg + 1 < SEG_N && tbl_dur[m_seg + 1] != 0) begin
                model_enter(m_seg + 1);
              end else if (LOOP && tbl_dur[0] != 0) begin
                model_enter(0);
                m_done = 1'b1;
              end else begin
                model_finish();
              end
            end
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
    if (bus.cfg_we) begin
      tbl_per[bus.cfg_addr] = int'(bus.cfg_per);
      tbl_dur[bus.cfg_addr] = int'(bus.cfg_dur);
    end
  endtask

  task automatic compare_model();
    check_val("pulse_en", longint'(bus.pulse_en), longint'(m_pulse));
    check_val("half_per", longint'(bus.half_per), longint'(m_half));
    check_val("busy", longint'(bus.busy), longint'(m_state == M_LOAD || m_state == M_RUN));
    check_val("done", longint'(bus.done), longint'(m_done));
    if (m_state == M_RUN) begin
      check_val("seg_idx", longint'(bus.seg_idx), longint'(m_seg));
      check_val("sec_cnt", longint'(bus.sec_cnt), longint'(m_sec));
    end
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_per = '0; bus.cfg_dur = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
    idle_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input int a, input int p, input int d);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'(a);
    bus.cfg_per = 23'(p);
    bus.cfg_dur = 9'(d);
    cyc();
  endtask

  task automatic go(input logic [1:0] m);
    bus.start = 1'b1;
    bus.mode = m;
    cyc();
  endtask

  task automatic halt();
    bus.stop = 1'b1;
    cyc();
  endtask

  initial begin
    foreach (tbl_per[i]) begin
      tbl_per[i] = 0;
      tbl_dur[i] = 0;
    end
    idle_inputs();
    reset = 1'b1;
    run(2);
    check_val("rst_pulse_en", longint'(bus.pulse_en), 0);
    check_val("rst_half_per", longint'(bus.half_per), 0);
    check_val("rst_seg_idx", longint'(bus.seg_idx), 0);
    check_val("rst_sec_cnt", longint'(bus.sec_cnt), 0);
    check_val("rst_busy", longint'(bus.busy), 0);
    check_val("rst_done", longint'(bus.done), 0);
    reset = 1'b0;
    for (int i = 0; i < int'(SEG_N); i++) wr(i, 1000 + i, 1);

    // Walk: rate two cycles after start, 3 s after 30 RUN cycles, stop.
    go(2'b00);
    cyc();
    check_val("walk_pulse", longint'(bus.pulse_en), 1);
    check_val("walk_per", longint'(bus.half_per), 1562500);
    run(30);
    check_val("walk_sec", longint'(bus.sec_cnt), 3);
    halt();
    check_val("walk_stop_pulse", longint'(bus.pulse_en), 0);
    check_val("walk_stop_done", longint'(bus.done), 0);

    // Hybrid {(100,2),(50,1),(0,0)}.
    wr(0, 100, 2); wr(1, 50, 1); wr(2, 0, 0);
    go(2'b11);
    cyc();
    check_val("hyb_seg0_per", longint'(bus.half_per), 100);
    run(19);
    check_val("hyb_seg0_hold", longint'(bus.half_per), 100);
    cyc();
    check_val("hyb_seg1_per", longint'(bus.half_per), 50);
    check_val("hyb_seg1_idx", longint'(bus.seg_idx), 1);
    run(9);
    check_val("hyb_seg1_hold", longint'(bus.half_per), 50);
    cyc();
    check_val("hyb_end_done", longint'(bus.done), 1);
    check_val("hyb_end_per", longint'(bus.half_per), LOOP ? 100 : 0);
    cyc();
    check_val("hyb_after_done", longint'(bus.done), 0);
    check_val("hyb_after_busy", longint'(bus.busy), longint'(LOOP));
    halt();

    // Empty profile: LOAD straight to DONE.
    wr(0, 123, 0);
    go(2'b11);
    cyc();
    check_val("empty_done", longint'(bus.done), 1);
    check_val("empty_pulse", longint'(bus.pulse_en), 0);
    cyc();
    check_val("empty_idle", longint'(bus.busy), 0);

    // All eight entries one second long.
    for (int i = 0; i < int'(SEG_N); i++) wr(i, 10 + i, 1);
    go(2'b11);
    cyc();
    run(70);
    check_val("full_seg7", longint'(bus.seg_idx), 7);
    check_val("full_per7", longint'(bus.half_per), 17);
    run(10);
    check_val("full_done", longint'(bus.done), 1);
    check_val("full_pulse", longint'(bus.pulse_en), longint'(LOOP));
    if (LOOP) check_val("full_wrap_idx", longint'(bus.seg_idx), 0);
    halt();

    // start+stop together in IDLE.
    bus.start = 1'b1; bus.stop = 1'b1; bus.mode = 2'b01;
    cyc();
    check_val("startstop_busy", longint'(bus.busy), 0);
    cyc();
    check_val("startstop_busy2", longint'(bus.busy), 0);

    // Reset mid-segment.
    go(2'b01);
    run(16);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_val("midrst_pulse", longint'(bus.pulse_en), 0);
    check_val("midrst_half", longint'(bus.half_per), 0);
    check_val("midrst_sec", longint'(bus.sec_cnt), 0);
    check_val("midrst_busy", longint'(bus.busy), 0);

    // Rewrite of the active entry does not change the running rate.
    wr(0, 100, 2); wr(1, 50, 2); wr(2, 0, 0);
    go(2'b11);
    cyc();
    run(20);
    check_val("live_seg1_per", longint'(bus.half_per), 50);
    wr(1, 77, 2);
    run(5);
    check_val("live_write_hold", longint'(bus.half_per), 50);
    halt();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) begin
        bus.start = 1'b1;
        bus.mode = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 149) == 0) bus.stop = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 3'($urandom_range(0, SEG_N - 1));
        bus.cfg_per = 23'($urandom);
        bus.cfg_dur = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom_range(1, 3));
      end
      cyc();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
